// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and counter sizing.
// Optional last_cause output is enabled with RESET_SEQ_CAUSE_EN.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SWRST   = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_POR       = 2'd0,
        CAUSE_LOCK_LOSS = 2'd1,
        CAUSE_SW        = 2'd2
    } cause_t;

    // Wide enough to hold the largest terminal count without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq_lock_sync.sv
// Two-flop synchroniser per PLL lock flag, AND-reduced into a single locked indication.
// Latency: two clock edges from a lock input change to locked_s.
module reset_seq_lock_sync
    import reset_seq_pkg::*;
#(
    parameter int NUM_PLLS = 2
) (
    input  logic                clock,
    input  logic                areset,
    input  logic [NUM_PLLS-1:0] pll_locked,
    output logic                locked_s
);

    logic [NUM_PLLS-1:0] meta;
    logic [NUM_PLLS-1:0] sync;

    // Flops clear to "unlocked" so a fresh reset always waits out the full stable window.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= pll_locked;
            sync <= meta;
        end
    end

    assign locked_s = &sync;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: waits for stable PLL locks, then releases domain resets in index order.
// All outputs registered; define RESET_SEQ_CAUSE_EN to add the last_cause output.
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS        = 4,
    parameter int NUM_PLLS           = 2,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int SW_HOLD_CYCLES     = 64
) (
    input  logic                   clock,
    input  logic                   areset,
    input  logic [NUM_PLLS-1:0]    pll_locked,
    input  logic                   sw_req,
    output logic                   sw_ack,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   seq_done,
    output logic [1:0]             seq_state
`ifdef RESET_SEQ_CAUSE_EN
    ,
    output logic [1:0]             last_cause
`endif
);

    localparam int CNT_W   = cnt_width(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES, SW_HOLD_CYCLES);
    localparam int STAGE_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SW_LAST    = CNT_W'(SW_HOLD_CYCLES - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_DOMAINS - 1);

    logic locked_s;

    seq_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STAGE_W-1:0]     stage_q, stage_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                   done_q, done_d;
    logic                   ack_q, ack_d;

    reset_seq_lock_sync #(
        .NUM_PLLS (NUM_PLLS)
    ) u_lock_sync (
        .clock      (clock),
        .areset     (areset),
        .pll_locked (pll_locked),
        .locked_s   (locked_s)
    );

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_d   = rst_q;
        done_d  = done_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_ASSERT: begin
                rst_d  = '1;
                done_d = 1'b0;
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d  = ST_RELEASE;
                    stage_d  = '0;
                    rst_d[0] = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        // Only clears bits, so released domains stay released.
                        for (int i = 1; i < NUM_DOMAINS; i++) begin
                            if (i == int'(stage_q) + 1) rst_d[i] = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (sw_req) begin
                    state_d = ST_SWRST;
                    rst_d   = '1;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_SWRST: begin
                if (cnt_q == SW_LAST) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // Lock loss outranks a software request and any counter expiry.
        if (state_q != ST_ASSERT && !locked_s) begin
            state_d = ST_ASSERT;
            rst_d   = '1;
            done_d  = 1'b0;
            ack_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    assign domain_reset = rst_q;
    assign seq_done     = done_q;
    assign sw_ack       = ack_q;
    assign seq_state    = state_q;

`ifdef RESET_SEQ_CAUSE_EN
    cause_t cause_q, cause_d;

    always_comb begin
        cause_d = cause_q;
        if (state_q != ST_ASSERT && !locked_s) cause_d = CAUSE_LOCK_LOSS;
        else if (ack_d)                        cause_d = CAUSE_SW;
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) cause_q <= CAUSE_POR;
        else        cause_q <= cause_d;
    end

    assign last_cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: expected output changes are queued with their edge number
// and matched against every observed change of {domain_reset, seq_done, sw_ack, seq_state}.
module tb_reset_seq_ctrl;
    import reset_seq_pkg::*;

    localparam int ND  = 4;
    localparam int NP  = 2;
    localparam int LSC = 8;
    localparam int GAP = 4;
    localparam int SWH = 6;

    logic          clock;
    logic          areset;
    logic [NP-1:0] pll_locked;
    logic          sw_req;
    logic          sw_ack;
    logic [ND-1:0] domain_reset;
    logic          seq_done;
    logic [1:0]    seq_state;
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0]    last_cause;
`endif

    reset_seq_ctrl #(
        .NUM_DOMAINS        (ND),
        .NUM_PLLS           (NP),
        .LOCK_STABLE_CYCLES (LSC),
        .STAGE_GAP_CYCLES   (GAP),
        .SW_HOLD_CYCLES     (SWH)
    ) dut (
        .clock        (clock),
        .areset       (areset),
        .pll_locked   (pll_locked),
        .sw_req       (sw_req),
        .sw_ack       (sw_ack),
        .domain_reset (domain_reset),
        .seq_done     (seq_done),
        .seq_state    (seq_state)
`ifdef RESET_SEQ_CAUSE_EN
        ,
        .last_cause   (last_cause)
`endif
    );

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    logic [7:0] prev;
    logic [7:0] cur;
    int         b, d, e;

    localparam logic [7:0] RST_TUPLE = {4'b1111, 1'b0, 1'b0, 2'd0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge number since the last areset release (edge 1 is the first edge after release).
    always @(posedge clock or posedge areset) begin
        if (areset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (areset) begin
            prev = RST_TUPLE;
        end else begin
            cur = {domain_reset, seq_done, sw_ack, seq_state};
            if (cur !== prev) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_change cyc=%0d observed=%b expected=none", cyc, cur);
                end
                if (exp_q.size() != 0) begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    checks++;
                    assert (cur === ev.val) else begin
                        errors++;
                        $error("FAIL out_value cyc=%0d observed=%b expected=%b", cyc, cur, ev.val);
                    end
                    checks++;
                    assert (cyc === ev.cyc) else begin
                        errors++;
                        $error("FAIL out_edge value=%b observed=%0d expected=%0d", cur, cyc, ev.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    function automatic void push_ev(input int t, input logic [3:0] r, input logic dn,
                                    input logic ak, input logic [1:0] st);
        ev_t ev;
        ev.cyc = t;
        ev.val = {r, dn, ak, st};
        exp_q.push_back(ev);
    endfunction

    // Release staircase starting at edge t0, then RUN one gap after the last release.
    function automatic void push_release(input int t0);
        logic [3:0] m;
        for (int i = 0; i < ND; i++) begin
            m = 4'b1111 << (i + 1);
            push_ev(t0 + i * GAP, m, 1'b0, 1'b0, ST_RELEASE);
        end
        push_ev(t0 + ND * GAP, 4'b0000, 1'b1, 1'b0, ST_RUN);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        #1;
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain pending observed=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        areset     = 1'b1;
        pll_locked = 2'b11;
        sw_req     = 1'b0;
        #12;
        chk("rst_domain_reset", 8'(domain_reset), 8'hF);
        chk("rst_seq_done", 8'(seq_done), 8'h0);
        chk("rst_sw_ack", 8'(sw_ack), 8'h0);
        chk("rst_seq_state", 8'(seq_state), 8'h0);
`ifdef RESET_SEQ_CAUSE_EN
        chk("rst_last_cause", 8'(last_cause), 8'h0);
`endif

        // Power-up with locks already steady.
        push_release(2 + LSC);
        #10 areset = 1'b0;
        wait_drain(60);

        // Software reset from RUN, then a request raised during RELEASE.
        goto(cyc + 1);
        b = cyc;
        sw_req = 1'b1;
        push_ev(b + 1, 4'b1111, 1'b0, 1'b1, ST_SWRST);
        push_ev(b + 2, 4'b1111, 1'b0, 1'b0, ST_SWRST);
        push_ev(b + 1 + SWH, 4'b1111, 1'b0, 1'b0, ST_ASSERT);
        push_release(b + 1 + SWH + LSC);
        goto(b + 1);
        sw_req = 1'b0;
`ifdef RESET_SEQ_CAUSE_EN
        chk("cause_sw", 8'(last_cause), 8'(CAUSE_SW));
`endif
        goto(b + 16);
        sw_req = 1'b1;
        push_ev(b + 32, 4'b1111, 1'b0, 1'b1, ST_SWRST);
        push_ev(b + 33, 4'b1111, 1'b0, 1'b0, ST_SWRST);
        push_ev(b + 38, 4'b1111, 1'b0, 1'b0, ST_ASSERT);
        push_ev(b + 46, 4'b1110, 1'b0, 1'b0, ST_RELEASE);
        push_ev(b + 50, 4'b1100, 1'b0, 1'b0, ST_RELEASE);
        push_ev(b + 53, 4'b1111, 1'b0, 1'b0, ST_ASSERT);
        goto(b + 32);
        sw_req = 1'b0;

        // Lock loss after the second domain has been released.
        goto(b + 50);
        pll_locked = 2'b00;
        goto(b + 53);
        chk("lossrel_domain_reset", 8'(domain_reset), 8'hF);
`ifdef RESET_SEQ_CAUSE_EN
        chk("cause_lossrel", 8'(last_cause), 8'(CAUSE_LOCK_LOSS));
`endif

        // Locks return; a one-cycle glitch at count 5 restarts the stable window.
        d = b + 56;
        goto(d);
        pll_locked = 2'b11;
        push_release(d + 18);
        goto(d + 7);
        pll_locked = 2'b01;
        goto(d + 8);
        pll_locked = 2'b11;

        // Lock loss and sw_req together in RUN: lock loss wins, no ack.
        e = d + 36;
        goto(e);
        chk("run_before_simul", 8'(seq_state), 8'(ST_RUN));
        pll_locked = 2'b10;
        push_ev(e + 3, 4'b1111, 1'b0, 1'b0, ST_ASSERT);
        goto(e + 2);
        sw_req = 1'b1;
        goto(e + 3);
        sw_req = 1'b0;
`ifdef RESET_SEQ_CAUSE_EN
        chk("cause_simul", 8'(last_cause), 8'(CAUSE_LOCK_LOSS));
`endif
        goto(e + 5);
        pll_locked = 2'b11;
        push_release(e + 15);
        wait_drain(60);

        // Asynchronous reset pulse mid-RUN.
        @(posedge clock);
        #2 areset = 1'b1;
        #1;
        chk("arst_domain_reset", 8'(domain_reset), 8'hF);
        chk("arst_seq_done", 8'(seq_done), 8'h0);
        chk("arst_seq_state", 8'(seq_state), 8'h0);
`ifdef RESET_SEQ_CAUSE_EN
        chk("arst_last_cause", 8'(last_cause), 8'(CAUSE_POR));
`endif
        push_release(2 + LSC);
        @(posedge clock);
        #1 areset = 1'b0;
        wait_drain(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
